series_sum_display: RTL and testbench
=====================================

# series_sum_display

Parametrised series accumulator with decimal 7-segment readout. On a `start` pulse it latches an operand N and a mode, and accumulates either Σk or Σk² for k = N down to 0, one term per cycle. It converts the result to BCD with a sequential double-dabble and drives NUM_DIGITS active-low 7-segment digits. It sits between the board switch/button inputs and the display bank, and replaces fixed-width, fixed-series summing.

## Interface
- N_WIDTH, 8: operand width.
- SUM_WIDTH, 20: result and accumulator width.
- NUM_DIGITS, 6: number of decimal display digits.
- Reset `rst`, synchronous, active-high; clock `clk`.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only in IDLE
- n_in  in  N_WIDTH  operand N, latched when start is accepted
- mode  in  1  0 = Σk, 1 = Σk²; latched with n_in
- busy  out  1  high in ACCUM, CONVERT and DONE
- done  out  1  one-cycle pulse, result valid
- overflow  out  1  result saturated or not displayable
- sum  out  SUM_WIDTH  final binary result, held until next done
- seg  out  7*NUM_DIGITS  digit i at bits [7i+6:7i], active-low gfedcba; digit 0 is least significant

## Operation
- FSM states: IDLE → ACCUM → CONVERT → DONE → IDLE.
- IDLE: when start=1, latch n_in into counter k and latch mode, clear the accumulator and the overflow flag, then go to ACCUM.
- ACCUM: each cycle add k (mode 0) or k*k (mode 1, 2*N_WIDTH-bit product) into a SUM_WIDTH+1-bit accumulator.
  - When k = 0, go to CONVERT; otherwise decrement k.
  - A carry into bit SUM_WIDTH sets sticky overflow. The accumulator then saturates at 2^SUM_WIDTH-1.
- CONVERT: double-dabble, one shift per cycle for exactly SUM_WIDTH cycles (add 3 to every BCD nibble ≥5, then shift).
  - If the value exceeds 10^NUM_DIGITS-1 (nonzero bits beyond NUM_DIGITS nibbles), set overflow.
- DONE: on the edge entering DONE, update sum and seg.
  - If overflow=0, each digit shows its BCD value.
  - If overflow=1, every digit shows a dash (7'b0111111).
  - done=1 for this cycle only, then return to IDLE.
- start is ignored outside IDLE. No queueing.
- sum, seg and overflow hold their values until the next DONE.
- n_in and mode changes after acceptance have no effect.

## Timing
- Reset values: state IDLE, busy=0, done=0, overflow=0, sum=0, seg = digit 0 showing "0" (7'b1000000), other digits per Configuration.
- start accepted at edge t: busy=1 from t. ACCUM occupies N+1 cycles and CONVERT occupies SUM_WIDTH cycles.
- done is high in the cycle following edge t+N+1+SUM_WIDTH+1. With defaults, latency is N+22 edges.
- start=1 in the same cycle done=1 is ignored. The next start can be accepted one cycle later, in IDLE.
- rst mid-operation: abort on the next edge and restore all reset values; no done pulse.
- N=0: one ACCUM cycle, result 0.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digits above the most significant nonzero digit show blank (7'b1111111). Digit 0 always shows a value. Dashes on overflow are unaffected.
- Not defined: all NUM_DIGITS digits show their value, including leading zeros. After reset all digits show "0".

## Test plan
- N=10, mode 0 → done 32 cycles after start, sum=55, overflow=0, seg digit0=7'b0010010, digit1=7'b0010010.
- N=10, mode 1 → sum=385, digit2 "3", digit1 "8", digit0 "5"; busy low the cycle after done.
- N=255, mode 1 (true 5559680 > 2^20-1) → overflow=1, sum=20'hFFFFF, all digits 7'b0111111. Then N=255, mode 0 → sum=32640, overflow=0.
- N=0, mode 0 → done 22 cycles after start, sum=0. Pulse start again during ACCUM → ignored, only one done.
- rst asserted 5 cycles into ACCUM with N=200 → next cycle busy=0, sum=0, seg at reset pattern, no done.
- With LEADING_ZERO_BLANK_EN, N=3, mode 0 → sum=6, digit0 "6", digits 1-5 = 7'b1111111. Without the macro, digits 1-5 = 7'b1000000.

Source files
------------

// File: rtl/series_sum_display.sv
// series_sum_display
// Accumulates sum(k) or sum(k^2) for k = N down to 0, one term per cycle.
// The result is converted to BCD with a sequential double-dabble and shown
// on NUM_DIGITS active-low gfedcba 7-segment digits.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the most
// significant nonzero digit. Digit 0 always shows a value.
module series_sum_display #(
    parameter int N_WIDTH    = 8,
    parameter int SUM_WIDTH  = 20,
    parameter int NUM_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_WIDTH-1:0]      n_in,
    input  logic                    mode,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [SUM_WIDTH-1:0]    sum,
    output logic [7*NUM_DIGITS-1:0] seg
);

    localparam int PROD_W     = 2 * N_WIDTH;
    localparam int ADD_W      = ((SUM_WIDTH + 1 > PROD_W) ? SUM_WIDTH + 1 : PROD_W) + 1;
    // ceil(W/3) decimal digits always hold a W-bit value
    localparam int DD_DIGITS  = (SUM_WIDTH + 2) / 3;
    localparam int BCD_DIGITS = (NUM_DIGITS > DD_DIGITS) ? NUM_DIGITS : DD_DIGITS;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int SH_W       = BCD_W + SUM_WIDTH;
    localparam int CNT_W      = $clog2(SUM_WIDTH + 1);
    localparam int SEG_W      = 7 * NUM_DIGITS;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [SEG_W-1:0] SEG_ALL_DASH = {NUM_DIGITS{SEG_DASH}};

    // Reset pattern: digit 0 shows "0", upper digits blank or "0" per build
    function automatic logic [SEG_W-1:0] reset_pattern();
        logic [SEG_W-1:0] p;
        p = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
            p[7*i +: 7] = (i == 0) ? SEG_ZERO : SEG_BLANK;
`else
            p[7*i +: 7] = SEG_ZERO;
`endif
        end
        return p;
    endfunction

    localparam logic [SEG_W-1:0] SEG_RESET = reset_pattern();

    // BCD digit to active-low gfedcba
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t             state;
    logic [N_WIDTH-1:0] k;
    logic               mode_q;
    logic [SUM_WIDTH:0] acc;
    logic               ov_flag;
    logic [CNT_W-1:0]   shift_cnt;
    logic [SH_W-1:0]    sh;

    logic [PROD_W-1:0]  sq;
    logic [ADD_W-1:0]   term;
    logic [ADD_W-1:0]   acc_sum;
    logic               acc_carry;
    logic [SUM_WIDTH:0] acc_next;

    logic [SH_W-1:0]    sh_adj;
    logic [SH_W-1:0]    sh_next;

    logic               hi_nonzero;
    logic               ov_final;
    logic [SEG_W-1:0]   seg_val;

    // Next accumulator value: add the current term, saturating on carry-out
    always_comb begin
        sq        = PROD_W'(k) * PROD_W'(k);
        term      = mode_q ? ADD_W'(sq) : ADD_W'(k);
        acc_sum   = ADD_W'(acc) + term;
        acc_carry = |acc_sum[ADD_W-1:SUM_WIDTH];
        acc_next  = acc_carry ? {1'b0, {SUM_WIDTH{1'b1}}} : acc_sum[SUM_WIDTH:0];
    end

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift
    always_comb begin
        sh_adj = sh;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (sh[SUM_WIDTH + 4*i +: 4] >= 4'd5)
                sh_adj[SUM_WIDTH + 4*i +: 4] = sh[SUM_WIDTH + 4*i +: 4] + 4'd3;
        end
        sh_next = sh_adj << 1;
    end

    // Decode converted BCD into display segments and detect undisplayable values
    always_comb begin
        logic       lead;
        logic [3:0] nib;
        int unsigned idx;
        hi_nonzero = 1'b0;
        for (int unsigned i = NUM_DIGITS; i < BCD_DIGITS; i++) begin
            if (sh[SUM_WIDTH + 4*i +: 4] != 4'd0)
                hi_nonzero = 1'b1;
        end
        ov_final = ov_flag | hi_nonzero;
        seg_val  = '1;
        lead     = 1'b1;
        nib      = '0;
        idx      = 0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            idx = NUM_DIGITS - 1 - j;
            nib = sh[SUM_WIDTH + 4*idx +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            if (lead && nib == 4'd0 && idx != 0) begin
                seg_val[7*idx +: 7] = SEG_BLANK;
            end else begin
                lead                = 1'b0;
                seg_val[7*idx +: 7] = seg7(nib);
            end
`else
            lead                = 1'b0;
            seg_val[7*idx +: 7] = seg7(nib);
`endif
        end
    end

    // Control FSM with registered outputs.
    // CONVERT spends SUM_WIDTH shift cycles plus one finalize cycle that
    // publishes sum/seg/overflow on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            k         <= '0;
            mode_q    <= 1'b0;
            acc       <= '0;
            ov_flag   <= 1'b0;
            shift_cnt <= '0;
            sh        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            sum       <= '0;
            seg       <= SEG_RESET;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k       <= n_in;
                        mode_q  <= mode;
                        acc     <= '0;
                        ov_flag <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc <= acc_next;
                    if (acc_carry)
                        ov_flag <= 1'b1;
                    if (k == '0) begin
                        sh        <= {{BCD_W{1'b0}}, acc_next[SUM_WIDTH-1:0]};
                        shift_cnt <= '0;
                        state     <= S_CONVERT;
                    end else begin
                        k <= k - N_WIDTH'(1);
                    end
                end
                S_CONVERT: begin
                    if (shift_cnt != CNT_W'(SUM_WIDTH)) begin
                        sh        <= sh_next;
                        shift_cnt <= shift_cnt + CNT_W'(1);
                    end else begin
                        sum      <= acc[SUM_WIDTH-1:0];
                        overflow <= ov_final;
                        seg      <= ov_final ? SEG_ALL_DASH : seg_val;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_series_sum_display.sv
// Directed self-checking bench for series_sum_display (default parameters).
module tb_series_sum_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  n_in;
    logic        mode;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [19:0] sum;
    logic [41:0] seg;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S6   = 7'b0000010;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] DASH = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ   = 7'b1111111;
`else
    localparam logic [6:0] LZ   = 7'b1000000;
`endif

    series_sum_display #(
        .N_WIDTH    (8),
        .SUM_WIDTH  (20),
        .NUM_DIGITS (6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n_in     (n_in),
        .mode     (mode),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .sum      (sum),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation; start stays high for `hold` cycles after acceptance
    task automatic run_op(input string tag, input int n, input logic m, input int hold,
                          input int exp_lat, input logic [19:0] exp_sum,
                          input logic exp_ovf, input logic [41:0] exp_seg);
        int cnt;
        int extra;
        bit seen;
        @(negedge clk);
        n_in  = 8'(n);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " busy_at_accept"}, 64'(busy), 64'd1);
        start = (hold > 0);
        n_in  = ~n_in;
        mode  = ~m;
        cnt   = 0;
        seen  = 0;
        while (!seen && cnt < 600) begin
            @(posedge clk);
            #1;
            cnt++;
            if (done)
                seen = 1;
            start = (cnt < hold);
        end
        if (!seen) begin
            check({tag, " done_timeout"}, 64'd0, 64'd1);
        end else begin
            check({tag, " latency"}, 64'(cnt), 64'(exp_lat));
            check({tag, " sum"}, 64'(sum), 64'(exp_sum));
            check({tag, " overflow"}, 64'(overflow), 64'(exp_ovf));
            check({tag, " seg"}, 64'(seg), 64'(exp_seg));
            check({tag, " busy_in_done"}, 64'(busy), 64'd1);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " busy_after_done"}, 64'(busy), 64'd0);
        check({tag, " done_pulse_width"}, 64'(done), 64'd0);
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done)
                extra++;
        end
        check({tag, " extra_done"}, 64'(extra), 64'd0);
        check({tag, " sum_held"}, 64'(sum), 64'(exp_sum));
    endtask

    initial begin
        int extra;
        rst   = 1'b1;
        start = 1'b0;
        n_in  = '0;
        mode  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        check("reset sum", 64'(sum), 64'd0);
        check("reset seg", 64'(seg), 64'({LZ, LZ, LZ, LZ, LZ, S0}));
        @(negedge clk);
        rst = 1'b0;

        run_op("n10_m0",  10,  1'b0, 0,  32,  20'd55,    1'b0, {LZ, LZ, LZ, LZ, S5, S5});
        run_op("n10_m1",  10,  1'b1, 0,  32,  20'd385,   1'b0, {LZ, LZ, LZ, S3, S8, S5});
        run_op("n255_m1", 255, 1'b1, 0,  277, 20'hFFFFF, 1'b1, {6{DASH}});
        run_op("n255_m0", 255, 1'b0, 0,  277, 20'd32640, 1'b0, {LZ, S3, S2, S6, S4, S0});
        // start held one extra cycle into ACCUM
        run_op("n0_m0",   0,   1'b0, 1,  22,  20'd0,     1'b0, {LZ, LZ, LZ, LZ, LZ, S0});
        // start held through the done cycle
        run_op("n3_hold", 3,   1'b0, 26, 25,  20'd6,     1'b0, {LZ, LZ, LZ, LZ, LZ, S6});

        // Reset in the middle of ACCUM
        @(negedge clk);
        n_in  = 8'd200;
        mode  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort sum", 64'(sum), 64'd0);
        check("abort overflow", 64'(overflow), 64'd0);
        check("abort seg", 64'(seg), 64'({LZ, LZ, LZ, LZ, LZ, S0}));
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (260) begin
            @(posedge clk);
            #1;
            if (done)
                extra++;
        end
        check("abort no_done", 64'(extra), 64'd0);
        check("abort idle_busy", 64'(busy), 64'd0);

        run_op("post_rst", 3, 1'b0, 0, 25, 20'd6, 1'b0, {LZ, LZ, LZ, LZ, LZ, S6});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
